debug_frame_tx: RTL

- Host-facing end of the CPU debug channel: snapshots the seven 8-bit debug port bytes and serialises them to the host debugger as one framed UART packet.
- Sits between the cpu top-level debug_port1..7 outputs and the board TX pin.
- The host-side serial debugger is the receiver; this block is the transmitter.

---
 rtl/debug_frame_tx_pkg.sv | 30 +++
 rtl/debug_frame_tx_uart_tx_byte.sv | 108 ++++++++++
 rtl/debug_frame_tx.sv | 87 ++++++++
 3 files changed

// File: rtl/debug_frame_tx_pkg.sv
// Shared types and constants for the debug frame transmitter.
// A frame is SYNC, seven debug port bytes, then an 8-bit wrap-around checksum.
package debug_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int unsigned FRAME_BYTES   = 9;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef logic [6:0][7:0] port_bytes_t;

    // Entries 0..6 hold debug_port1..7, entry 7 holds the checksum.
    typedef logic [7:0][7:0] payload_t;

    function automatic logic [7:0] port_sum(input port_bytes_t p);
        logic [7:0] s;
        s = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            s = s + p[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/debug_frame_tx_uart_tx_byte.sv
// 8N1 UART byte transmitter with a load/ready handshake.
// A load accepted in the done cycle starts the next start bit with no idle gap.
module uart_tx_byte
    import debug_frame_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready,
    output logic       done,
    output logic       active
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST = 3'(BITS_PER_BYTE - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        txd_q, txd_d;
    logic        cnt_last;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        cnt_last = (cnt_q == CNT_LAST);
        done     = (state_q == ST_STOP) && cnt_last;
        ready    = (state_q == ST_IDLE) || done;
        active   = (state_q != ST_IDLE);

        if (state_q != ST_IDLE) begin
            cnt_d = cnt_last ? '0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_START;
                    shreg_d = data;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (cnt_last) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // txd already shows shreg_q[0]; present the next bit as we shift.
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (cnt_last) begin
                    if (load) begin
                        state_d = ST_START;
                        shreg_d = data;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots debug_port1..7 on send and streams SYNC, the seven bytes and a
// checksum as one back-to-back 8N1 frame to the host debugger.
module debug_frame_tx
    import debug_frame_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       send,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    payload_t    payload_q, payload_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    port_bytes_t ports_in;
    logic        accept;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_active;

    assign ports_in = {debug_port7, debug_port6, debug_port5, debug_port4,
                       debug_port3, debug_port2, debug_port1};

    always_comb begin
        payload_d  = payload_q;
        byte_idx_d = byte_idx_q;
        tx_load    = 1'b0;
        tx_data    = SYNC_BYTE;
        frame_done = tx_done && (byte_idx_q == LAST_BYTE);
        // Busy drops in the final stop-bit cycle so a new send can chain with no gap.
        busy       = tx_active && !frame_done;
        accept     = send && tx_ready && !busy;

        if (accept) begin
            payload_d  = {port_sum(ports_in), ports_in};
            byte_idx_d = '0;
            tx_load    = 1'b1;
            tx_data    = SYNC_BYTE;
        end else if (tx_done && (byte_idx_q < LAST_BYTE)) begin
            // Byte k+1 of the frame lives in payload entry k.
            tx_load    = 1'b1;
            tx_data    = payload_q[byte_idx_q[2:0]];
            byte_idx_d = byte_idx_q + 4'd1;
        end else if (frame_done) begin
            byte_idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            payload_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            payload_q  <= payload_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .nreset(nreset),
        .load  (tx_load),
        .data  (tx_data),
        .txd   (txd),
        .ready (tx_ready),
        .done  (tx_done),
        .active(tx_active)
    );

endmodule
